// File: rtl/regfile_ctx_seq.sv
// regfile_ctx_seq: context save/restore sequencer for the LC-3 8x16 register file.
// While busy it owns the register-file ports (rf_own) and streams R0..R7 to
// memory at base+idx (save) or loads them back from base+idx (restore).
// Optional build macro: REGFILE_CTX_SKIP_R6_EN -- when defined, R6 (USP) is
// skipped in both directions (idx steps 5 -> 7); the frame layout is unchanged.
//
// Memory handshake: mem_req is raised in SV_WR / RS_RD and held, together with
// mem_we / mem_addr / mem_wdata, until mem_ack is sampled high on a rising
// edge; the transfer completes on that edge and mem_req drops in the next cycle.
module regfile_ctx_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              rf_own,
  output logic [2:0]        rf_sr1,
  input  logic [DATA_W-1:0] rf_sr1out,
  output logic [2:0]        rf_dr,
  output logic              rf_ld,
  output logic [DATA_W-1:0] rf_bus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SV_RD = 3'd1,
    ST_SV_WR = 3'd2,
    ST_RS_RD = 3'd3,
    ST_RS_WR = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        idx;
  logic [2:0]        idx_nxt;
  logic              last_reg;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] rf_bus_q;

  // Register walk order and frame addresses (mod 2^ADDR_W, wrap is silent).
  always_comb begin
`ifdef REGFILE_CTX_SKIP_R6_EN
    idx_nxt = (idx == 3'd5) ? 3'd7 : idx + 3'd1;
`else
    idx_nxt = idx + 3'd1;
`endif
    last_reg = (idx == 3'd7);
    addr_cur = base + {{(ADDR_W-3){1'b0}}, idx};
    addr_nxt = base + {{(ADDR_W-3){1'b0}}, idx_nxt};
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; save wins over a simultaneous restore, and requests
  // outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (save_req)         state_nxt = ST_SV_RD;
        else if (restore_req) state_nxt = ST_RS_RD;
      end
      ST_SV_RD: state_nxt = ST_SV_WR;
      ST_SV_WR: if (mem_ack) state_nxt = last_reg ? ST_DONE : ST_SV_RD;
      ST_RS_RD: if (mem_ack) state_nxt = ST_RS_WR;
      ST_RS_WR: state_nxt = last_reg ? ST_DONE : ST_RS_RD;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: frame base, register index and the registered memory/rf values.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= 3'd0;
      base        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rf_bus_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (save_req || restore_req) begin
            base       <= base_addr;
            idx        <= 3'd0;
            mem_addr_q <= base_addr;   // R0 address for a restore
            mem_we_q   <= 1'b0;
          end
        end
        ST_SV_RD: begin
          mem_wdata_q <= rf_sr1out;
          mem_addr_q  <= addr_cur;
          mem_we_q    <= 1'b1;
        end
        ST_SV_WR: begin
          if (mem_ack && !last_reg) idx <= idx_nxt;
        end
        ST_RS_RD: begin
          if (mem_ack) rf_bus_q <= mem_rdata;
        end
        ST_RS_WR: begin
          if (!last_reg) begin
            idx        <= idx_nxt;
            mem_addr_q <= addr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-state control outputs.
  always_comb begin
    busy    = 1'b0;
    rf_own  = 1'b0;
    done    = 1'b0;
    mem_req = 1'b0;
    rf_ld   = 1'b0;
    rf_sr1  = 3'd0;
    rf_dr   = 3'd0;
    case (state)
      ST_SV_RD: begin
        busy   = 1'b1;
        rf_own = 1'b1;
        rf_sr1 = idx;
      end
      ST_SV_WR, ST_RS_RD: begin
        busy    = 1'b1;
        rf_own  = 1'b1;
        mem_req = 1'b1;
      end
      ST_RS_WR: begin
        busy   = 1'b1;
        rf_own = 1'b1;
        rf_ld  = 1'b1;
        rf_dr  = idx;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rf_bus    = rf_bus_q;

endmodule

// File: tb/tb_regfile_ctx_seq.sv
// tb_regfile_ctx_seq: directed bench for regfile_ctx_seq with a register-file
// model, a wait-state memory model and scoreboard queues for memory writes,
// memory reads and register-file loads.
module tb_regfile_ctx_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_req;
  logic        restore_req;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;
  logic        rf_own;
  logic [2:0]  rf_sr1;
  logic [15:0] rf_sr1out;
  logic [2:0]  rf_dr;
  logic        rf_ld;
  logic [15:0] rf_bus;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int wcnt   = 0;

  logic [15:0] rf  [8];
  logic [15:0] mem [0:65535];

  logic [31:0] exp_wr_q [$];   // {addr, data}
  logic [15:0] exp_rd_q [$];   // addr
  logic [18:0] exp_ld_q [$];   // {dr, data}

  regfile_ctx_seq #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .base_addr(base_addr), .busy(busy), .done(done), .rf_own(rf_own),
    .rf_sr1(rf_sr1), .rf_sr1out(rf_sr1out), .rf_dr(rf_dr), .rf_ld(rf_ld),
    .rf_bus(rf_bus), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign rf_sr1out = rf[rf_sr1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder and scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] ew;
    logic [18:0] el;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wcnt == wait_n) begin
        mem_ack = 1'b1;
        wcnt = 0;
        if (mem_we) begin
          check("write_expected", 64'(exp_wr_q.size() != 0), 64'd1);
          if (exp_wr_q.size() != 0) begin
            ew = exp_wr_q.pop_front();
            check("mem_write", {mem_addr, mem_wdata}, ew);
          end
          mem[mem_addr] = mem_wdata;
        end else begin
          check("read_expected", 64'(exp_rd_q.size() != 0), 64'd1);
          if (exp_rd_q.size() != 0) check("mem_read_addr", mem_addr, exp_rd_q.pop_front());
          mem_rdata = mem[mem_addr];
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    if (rf_ld) begin
      check("ld_expected", 64'(exp_ld_q.size() != 0), 64'd1);
      if (exp_ld_q.size() != 0) begin
        el = exp_ld_q.pop_front();
        check("rf_load", {rf_dr, rf_bus}, el);
      end
      rf[rf_dr] = rf_bus;
    end
  end

  function automatic logic [59:0] all_outs();
    return {busy, done, rf_own, rf_sr1, rf_dr, rf_ld, rf_bus, mem_req, mem_we,
            mem_addr, mem_wdata};
  endfunction

  function automatic bit reg_used(input int n);
`ifdef REGFILE_CTX_SKIP_R6_EN
    return n != 6;
`else
    return 1'b1;
`endif
  endfunction

  // Pulse a start, optionally inject a stray restore_req, and count cycles to done.
  task automatic run_op(input logic sv, input logic rs, input logic [15:0] base,
                        input int inject_at, output int lat, output logic own_ok);
    @(negedge clk);
    save_req = sv; restore_req = rs; base_addr = base;
    @(negedge clk);
    save_req = 1'b0; restore_req = 1'b0; base_addr = 16'h0;
    lat = 1;
    own_ok = 1'b1;
    while (!done && lat < 300) begin
      if (!busy || !rf_own) own_ok = 1'b0;
      restore_req = (lat == inject_at);
      @(negedge clk);
      lat++;
    end
    restore_req = 1'b0;
    check("done_seen", done, 1'b1);
    check("done_busy_own", {busy, rf_own}, 2'b00);
  endtask

  initial begin
    int lat;
    logic own_ok;
    logic [15:0] a;
    int exp_save, exp_rest, exp_wrap;
    bit done_seen;
`ifdef REGFILE_CTX_SKIP_R6_EN
    exp_save = 15; exp_rest = 36; exp_wrap = 22;
`else
    exp_save = 17; exp_rest = 41; exp_wrap = 25;
`endif
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0; base_addr = 16'h0;
    for (int n = 0; n < 8; n++) rf[n] = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 60'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outs(), 60'h0);

    // Save, zero-wait memory.
    wait_n = 0;
    mem[16'h3006] = 16'hDEAD;
    for (int n = 0; n < 8; n++) rf[n] = 16'(16'h1110 * (n + 1));
    for (int n = 0; n < 8; n++)
      if (reg_used(n)) exp_wr_q.push_back({16'(16'h3000 + n), 16'(16'h1110 * (n + 1))});
    run_op(1'b1, 1'b0, 16'h3000, -1, lat, own_ok);
    check("save_latency", lat, exp_save);
    check("save_busy_own", own_ok, 1'b1);
    check("save_wr_q_empty", exp_wr_q.size(), 0);
`ifdef REGFILE_CTX_SKIP_R6_EN
    check("save_x3006_untouched", mem[16'h3006], 16'hDEAD);
`else
    check("save_x3006", mem[16'h3006], 16'h7770);
`endif

    // Restore with three wait cycles per access.
    wait_n = 3;
    for (int n = 0; n < 8; n++) begin
      rf[n] = 16'h0;
      mem[16'(16'h4000 + n)] = 16'(16'hA000 + n);
      if (reg_used(n)) begin
        exp_rd_q.push_back(16'(16'h4000 + n));
        exp_ld_q.push_back({3'(n), 16'(16'hA000 + n)});
      end
    end
    run_op(1'b0, 1'b1, 16'h4000, -1, lat, own_ok);
    check("restore_latency", lat, exp_rest);
    check("restore_busy_own", own_ok, 1'b1);
    check("restore_queues_empty", {exp_rd_q.size(), exp_ld_q.size()}, 64'h0);
    for (int n = 0; n < 8; n++)
      check($sformatf("restore_r%0d", n), rf[n], reg_used(n) ? 16'(16'hA000 + n) : 16'h0);

    // Contention: both requests together, then a stray restore mid-save.
    wait_n = 0;
    for (int n = 0; n < 8; n++) begin
      rf[n] = 16'(16'h2000 + n);
      if (reg_used(n)) exp_wr_q.push_back({16'(16'h5000 + n), 16'(16'h2000 + n)});
    end
    run_op(1'b1, 1'b1, 16'h5000, 5, lat, own_ok);
    check("contend_latency", lat, exp_save);
    check("contend_wr_q_empty", exp_wr_q.size(), 0);
    repeat (3) @(negedge clk);
    check("contend_stays_idle", {busy, mem_req}, 2'b00);

    // Reset in RS_RD of R3 during a restore.
    wait_n = 3;
    for (int n = 0; n < 8; n++) begin
      rf[n] = 16'(16'h5550 + n);
      mem[16'(16'h6000 + n)] = 16'(16'hB000 + n);
    end
    for (int n = 0; n < 3; n++) begin
      exp_rd_q.push_back(16'(16'h6000 + n));
      exp_ld_q.push_back({3'(n), 16'(16'hB000 + n)});
    end
    @(negedge clk);
    restore_req = 1'b1; base_addr = 16'h6000;
    @(negedge clk);
    restore_req = 1'b0; base_addr = 16'h0;
    repeat (15) @(negedge clk);
    check("abort_in_rs_rd_r3", {mem_req, mem_we, mem_addr}, {2'b10, 16'h6003});
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", all_outs(), 60'h0);
    reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || rf_ld || mem_req) done_seen = 1'b1;
    end
    check("abort_quiet", done_seen, 1'b0);
    check("abort_queues_empty", {exp_rd_q.size(), exp_ld_q.size()}, 64'h0);
    for (int n = 0; n < 8; n++)
      check($sformatf("abort_r%0d", n), rf[n],
            (n < 3) ? 16'(16'hB000 + n) : 16'(16'h5550 + n));

    // Save after the abort, base wraps past xFFFF, one wait cycle.
    wait_n = 1;
    for (int n = 0; n < 8; n++) begin
      rf[n] = 16'($urandom_range(0, 65535));
      a = 16'hFFFC + 16'(n);
      if (reg_used(n)) exp_wr_q.push_back({a, rf[n]});
    end
    run_op(1'b1, 1'b0, 16'hFFFC, -1, lat, own_ok);
    check("wrap_latency", lat, exp_wrap);
    check("wrap_wr_q_empty", exp_wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_ctx_seq.md
Name: regfile_ctx_seq

Overview:
- Context save/restore sequencer for the LC-3 8x16 register file.
- On request, it takes ownership of the register-file ports and streams R0..R7 out to memory (save), or loads them back from memory (restore).
- Used by the interrupt/trap path and by the BCI host debug path to snapshot and reload CPU state.
- Sits beside the register file, muxed against the normal datapath controls via rf_own.

Parameters:
- DATA_W, 16, register and memory data width.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- save_req  in  1  one-cycle start pulse for a save.
- restore_req  in  1  one-cycle start pulse for a restore.
- base_addr  in  ADDR_W  frame base address; sampled on accepted start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of an operation.
- rf_own  out  1  high while busy; steers the register-file DR/SR1/LD_REG/BUS mux to this block.
- rf_sr1  out  3  register-file read address.
- rf_sr1out  in  DATA_W  register-file read data; combinational from rf_sr1.
- rf_dr  out  3  register-file write address.
- rf_ld  out  1  register-file write enable.
- rf_bus  out  DATA_W  register-file write data.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory acknowledge; may assert in any cycle mem_req is high, including the first.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx = 0.
- Reset mid-operation aborts immediately. No further rf_ld or mem_req is issued, and done does not pulse.
- States: IDLE, SV_RD, SV_WR, RS_RD, RS_WR, DONE.
- IDLE:
  - save_req -> latch base_addr, idx = first register, go to SV_RD.
  - else restore_req -> same latching, go to RS_RD.
  - Both requests high in the same cycle: save wins; restore is dropped.
  - Requests arriving while not in IDLE are ignored and not queued.
- SV_RD (1 cycle):
  - Drive rf_sr1 = idx.
  - Register mem_wdata = rf_sr1out, mem_addr = base + idx, mem_we = 1.
  - Go to SV_WR.
- SV_WR:
  - mem_req = 1 until mem_ack is sampled high; mem_addr and mem_wdata held stable.
  - On ack: last register -> DONE; else idx = next register, go to SV_RD.
  - mem_req is 0 in the cycle after ack.
- RS_RD:
  - mem_req = 1, mem_we = 0, mem_addr = base + idx.
  - On ack: capture mem_rdata into rf_bus, go to RS_WR.
- RS_WR (1 cycle):
  - rf_ld = 1, rf_dr = idx.
  - Last register -> DONE; else idx = next register, go to RS_RD.
- DONE (1 cycle): done = 1, busy = 0, rf_own = 0; next cycle IDLE.
- busy and rf_own are high in every SV_*/RS_* state.
- rf_ld is high only in RS_WR.
- Address arithmetic: base + idx is computed mod 2^ADDR_W. Wrap-around at xFFFF is legal and silent (e.g. base xFFFE, R2 -> x0000).
- Latency with zero-wait memory (ack in first request cycle):
  - 2 cycles per register.
  - 8 registers: done pulses 17 cycles after the start cycle.
  - Each extra wait cycle adds 1.

Optional Feature:
- REGFILE_CTX_SKIP_R6_EN
  - Defined: R6 (USP) is neither saved nor restored; idx goes 5 -> 7.
  - The frame keeps the fixed layout base+idx, so the base+6 location is left untouched.
  - 7 registers take 2 cycles each: done 15 cycles after start with zero-wait memory.
  - Undefined: all of R0..R7 are transferred.

Test Plan:
- Save, zero-wait: Rn = x1110*(n+1) mod 2^16, base = x3000, save_req pulse -> 8 memory writes x3000..x3007 with data x1110, x2220, ..., x8880 in order; done exactly 17 cycles after start; rf_ld never high.
- Restore with wait states: memory x4000..x4007 = xA000+n, mem_ack delayed 3 cycles each -> Rn = xA000+n; 8 rf_ld pulses; done 41 cycles after start; busy and rf_own continuously high until DONE.
- Contention: save_req and restore_req in the same cycle -> save performed. A restore_req pulse mid-save is ignored: exactly 8 writes, no reads.
- Wrap: base = xFFFC, save -> addresses xFFFC, xFFFD, xFFFE, xFFFF, x0000..x0003.
- Reset mid-restore: assert reset in RS_RD of R3 -> next cycle all outputs 0; R0..R2 updated, R3..R7 unchanged; no done pulse; a subsequent save works normally.
- With REGFILE_CTX_SKIP_R6_EN, save at base x3000 -> 7 writes, no write to x3006; done after 15 cycles.
